// File: rtl/gpio_pattern_checker.sv
// Tracks a remote free-running 8-bit up-counter on an asynchronous GPIO bus,
// declaring lock after a run of good increments and counting mismatches while locked.
module gpio_pattern_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  gpio_in,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [15:0] good_count,
    output logic [7:0]  last_bad
);

    localparam int DATA_W = 8;
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] prev_inc;
    logic              vld_p0;
    logic              vld_p1;
    logic              vld_p2;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        run_cnt;
    logic [3:0]        run_nxt;
    logic [3:0]        miss_cnt;
    logic [3:0]        miss_nxt;
    logic              match;
    logic              good_hit;
    logic              err_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage 0/1: two-flop synchronizer, prev holds the previous checked sample.
    // The vld_p* chain marks when both s2 and prev carry post-reset samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1     <= '0;
            s2     <= '0;
            prev   <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            s1     <= gpio_in;
            s2     <= s1;
            prev   <= s2;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    assign prev_inc = prev + 1'b1;
    assign match    = (s2 == prev_inc);

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        miss_nxt  = miss_cnt;
        good_hit  = 1'b0;
        err_hit   = 1'b0;
        if (vld_p2) begin
            case (state)
                HUNT: begin
                    if (!match) begin
                        run_nxt = '0;
                    end else if (run_cnt == LOCK_LAST) begin
                        state_nxt = LOCKED;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_cnt + 4'd1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        good_hit = 1'b1;
                        miss_nxt = '0;
                    end else begin
                        // The mismatch that drops lock is still counted and reported.
                        err_hit = 1'b1;
                        if (miss_cnt == LOSS_LAST) begin
                            state_nxt = HUNT;
                            miss_nxt  = '0;
                            run_nxt   = '0;
                        end else begin
                            miss_nxt = miss_cnt + 4'd1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Stage 2: FSM state and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= HUNT;
            run_cnt    <= '0;
            miss_cnt   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            good_count <= '0;
            last_bad   <= '0;
        end else begin
            state     <= state_nxt;
            run_cnt   <= run_nxt;
            miss_cnt  <= miss_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= err_hit;
            if (err_hit) begin
                last_bad <= s2;
            end
            if (clear) begin
                err_count  <= '0;
                good_count <= '0;
            end else begin
                if (err_hit) begin
                    err_count <= sat_inc(err_count);
                end
                if (good_hit) begin
                    good_count <= sat_inc(good_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_pattern_checker.sv
// Randomized and directed bench for gpio_pattern_checker against a sample-history
// reference model that compares each sample with the one before it.
module tb_gpio_pattern_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear;
    logic [7:0]  gpio_in;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] good_count;
    logic [7:0]  last_bad;
    logic [41:0] obs;

    gpio_pattern_checker #(
        .LOCK_COUNT(LOCK),
        .LOSS_COUNT(LOSS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .gpio_in(gpio_in),
        .clear(clear),
        .locked(locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .good_count(good_count),
        .last_bad(last_bad)
    );

    always #5 clk = ~clk;

    assign obs = {locked, err_pulse, err_count, good_count, last_bad};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the history of samples seen since reset release.
    logic [7:0] hist[$];
    bit         m_locked;
    bit         m_pulse;
    int         m_run;
    int         m_miss;
    int         m_err;
    int         m_good;
    logic [7:0] m_last;
    logic [7:0] cv;

    function automatic logic [41:0] exp_vec();
        return {m_locked, m_pulse, 16'(m_err), 16'(m_good), m_last};
    endfunction

    task automatic model_reset();
        hist.delete();
        m_locked = 1'b0;
        m_pulse  = 1'b0;
        m_run    = 0;
        m_miss   = 0;
        m_err    = 0;
        m_good   = 0;
        m_last   = 8'h00;
    endtask

    // A sample becomes visible at the outputs two edges after it was captured,
    // and it is judged against the sample captured one edge earlier.
    task automatic model_edge(input logic [7:0] v, input logic clr);
        logic [7:0] cur;
        logic [7:0] prv;
        hist.push_back(v);
        m_pulse = 1'b0;
        if (hist.size() >= 4) begin
            cur = hist[hist.size() - 3];
            prv = hist[hist.size() - 4];
            if (!m_locked) begin
                if (cur == 8'(prv + 8'd1)) begin
                    m_run = m_run + 1;
                    if (m_run == LOCK) begin
                        m_locked = 1'b1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (cur == 8'(prv + 8'd1)) begin
                if (m_good < 65535) m_good = m_good + 1;
                m_miss = 0;
            end else begin
                m_pulse = 1'b1;
                if (m_err < 65535) m_err = m_err + 1;
                m_last = cur;
                m_miss = m_miss + 1;
                if (m_miss == LOSS) begin
                    m_locked = 1'b0;
                    m_miss   = 0;
                    m_run    = 0;
                end
            end
        end
        if (clr) begin
            m_err  = 0;
            m_good = 0;
        end
    endtask

    // Entered and left at a falling edge.
    task automatic step(input logic [7:0] v, input logic c);
        gpio_in = v;
        clear   = c;
        @(posedge clk);
        #1;
        model_edge(v, c);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (obs !== 42'd0) $display("FAIL reset_state: got %h want %h", obs, 42'd0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            gpio_in = 8'($urandom);
            clear   = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (obs !== 42'd0) $display("FAIL reset_hold: got %h want %h", obs, 42'd0);
            else n_pass++;
        end
        clear  = 1'b0;
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step(8'($urandom), 1'b0);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL post_reset_suppress: got %h want %h", obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        int edges;
        logic [15:0] g0;
        apply_reset();
        n_checks++;
        if (obs !== 42'd0) $display("FAIL lock_reset: got %h want %h", obs, 42'd0);
        else n_pass++;
        release_reset();
        cv = 8'h00;
        edges = 0;
        while (locked !== 1'b1 && edges < 3 + LOCK + 2) begin
            step(cv, 1'b0);
            cv++;
            edges++;
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL lock_seq: got %h want %h", obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (locked !== 1'b1) $display("FAIL lock_time: got locked=%0b after %0d edges want 1", locked, edges);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            g0 = good_count;
            step(cv, 1'b0);
            cv++;
            n_checks++;
            if (good_count !== g0 + 16'd1 || err_count !== 16'd0)
                $display("FAIL good_step: got good=%h err=%h want good=%h err=0", good_count, err_count, g0 + 16'd1);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] g0;
        int pulses;
        while (cv != 8'hFE) begin
            step(cv, 1'b0);
            cv++;
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL wrap_run: got %h want %h", obs, exp_vec());
            else n_pass++;
        end
        pulses = 0;
        g0 = 16'd0;
        for (int i = 0; i < 6; i++) begin
            step(cv, 1'b0);
            cv++;
            pulses += int'(err_pulse);
            if (i == 2) g0 = good_count;
        end
        n_checks++;
        if (pulses !== 0 || good_count !== g0 + 16'd3)
            $display("FAIL wrap_ff_00: got pulses=%0d good=%h want pulses=0 good=%h", pulses, good_count, g0 + 16'd3);
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [7:0] seq [7] = '{8'h10, 8'h11, 8'h55, 8'h13, 8'h14, 8'h15, 8'h16};
        int pulses;
        while (cv != 8'h10) begin
            step(cv, 1'b0);
            cv++;
        end
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            step(seq[i], 1'b0);
            pulses += int'(err_pulse);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL glitch_seq: got %h want %h", obs, exp_vec());
            else n_pass++;
        end
        cv = 8'h17;
        n_checks++;
        if (pulses !== 2 || err_count !== 16'd2 || last_bad !== 8'h13 || locked !== 1'b1)
            $display("FAIL glitch_result: got pulses=%0d err=%h last=%h lk=%0b want 2 0002 13 1",
                     pulses, err_count, last_bad, locked);
        else n_pass++;
    endtask

    task automatic test_static();
        int pulses;
        while (cv != 8'h3F) begin
            step(cv, 1'b0);
            cv++;
        end
        step(8'h3F, 1'b1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step((i < 5) ? 8'h40 : 8'(8'h41 + i - 5), 1'b0);
            pulses += int'(err_pulse);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL static_seq: got %h want %h", obs, exp_vec());
            else n_pass++;
        end
        cv = 8'h44;
        n_checks++;
        if (pulses !== 3 || err_count !== 16'd3 || locked !== 1'b0)
            $display("FAIL static_result: got pulses=%0d err=%h lk=%0b want 3 0003 0", pulses, err_count, locked);
        else n_pass++;
    endtask

    task automatic relock(input string tag);
        int edges;
        edges = 0;
        while (locked !== 1'b1 && edges < 3 + LOCK + 2) begin
            step(cv, 1'b0);
            cv++;
            edges++;
        end
        n_checks++;
        if (locked !== 1'b1 || obs !== exp_vec())
            $display("FAIL %s: got %h want %h", tag, obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [7:0] bad;
        relock("sat_relock");
        force dut.err_count = 16'hFFFE;
        #1;
        release dut.err_count;
        m_err = 32'hFFFE;
        step(cv, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step((i < 3) ? cv : 8'(cv + i - 2), 1'b0);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL sat_seq: got %h want %h", obs, exp_vec());
            else n_pass++;
        end
        cv = cv + 8'd3;
        n_checks++;
        if (err_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", err_count);
        else n_pass++;
        relock("clr_relock");
        bad = cv ^ 8'h80;
        step(bad, 1'b0);
        step(bad + 8'd1, 1'b0);
        step(bad + 8'd2, 1'b1);
        cv = bad + 8'd3;
        n_checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd0 || good_count !== 16'd0 || last_bad !== bad)
            $display("FAIL clear_vs_err: got p=%0b err=%h good=%h last=%h want 1 0000 0000 %h",
                     err_pulse, err_count, good_count, last_bad, bad);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int edges;
        step(cv, 1'b0);
        cv++;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL arst_pre: got locked=%0b want 1", locked);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (obs !== 42'd0) $display("FAIL arst_immediate: got %h want %h", obs, 42'd0);
        else n_pass++;
        release_reset();
        cv = 8'($urandom);
        edges = 0;
        while (locked !== 1'b1 && edges < 3 + LOCK + 2) begin
            step(cv, 1'b0);
            cv++;
            edges++;
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL arst_relock_seq: got %h want %h", obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (locked !== 1'b1) $display("FAIL arst_relock: got locked=%0b after %0d edges want 1", locked, edges);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        logic [7:0] v;
        logic c;
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(99));
            if (r < 82) begin
                v = cv;
                cv++;
            end else if (r < 88) begin
                v = cv - 8'd1;
            end else if (r < 94) begin
                v = 8'($urandom);
                cv = v + 8'd1;
            end else begin
                v = cv + 8'd1;
                cv = cv + 8'd2;
            end
            c = ($urandom_range(49) == 0);
            step(v, c);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        resetn  = 1'b0;
        clear   = 1'b0;
        gpio_in = 8'h00;
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_glitch();
        test_static();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
